// File: rtl/lz_insert.sv
// Purpose : denormalizer that right-shifts a value to re-insert a requested number of leading zeros, with a sticky OR of the shifted-out bits.
// Latency : S+1 enabled cycles from accepted ld to done, where S = floor(c/8) + (c mod 8) and c = min(cnt, WID).
// Backpress: no queueing; ld is only honoured in IDLE, and ce=0 freezes every register including done.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (overrides ce)
//   ce         clock enable for all state
//   ld, i, cnt start request, operand and leading-zero count (sampled together in IDLE)
//   o, sticky  result and OR of the discarded bits; held from done until the next accepted ld
//   busy       high from the cycle after an accepted ld through the done cycle
//   done       single enabled-cycle completion pulse
//
// WID must be a multiple of 8 and at least 8; the byte step relies on it.
module lz_insert #(
  parameter int WID = 64,
  parameter int CW  = $clog2(WID) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           ld,
  input  logic [WID-1:0] i,
  input  logic [CW-1:0]  cnt,
  output logic [WID-1:0] o,
  output logic           sticky,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WID_C  = CW'(WID);
  localparam logic [CW-1:0] BYTE_C = CW'(8);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  rem;
  logic [CW-1:0]  rem_nxt;
  logic [CW-1:0]  cnt_clamp;
  logic [WID-1:0] o_nxt;
  logic           sticky_nxt;

  // Counts beyond the width shift everything out; clamping keeps the step
  // count bounded and makes the result o=0, sticky=|i.
  always_comb begin
    cnt_clamp = (cnt > WID_C) ? WID_C : cnt;
  end

  // Next-state and datapath. Whole bytes are consumed first, then the
  // remaining 0..7 positions one bit at a time; rem never goes below zero
  // because the byte step is only taken when rem >= 8 and the bit step only
  // runs in SHIFT, which is entered with rem > 0.
  always_comb begin
    state_nxt  = state;
    o_nxt      = o;
    sticky_nxt = sticky;
    rem_nxt    = rem;

    case (state)
      IDLE: begin
        if (ld) begin
          o_nxt      = i;
          sticky_nxt = 1'b0;
          rem_nxt    = cnt_clamp;
          state_nxt  = (cnt_clamp == '0) ? DONE : SHIFT;
        end
      end

      SHIFT: begin
        if (rem >= BYTE_C) begin
          o_nxt      = o >> 8;
          sticky_nxt = sticky | (|o[7:0]);
          rem_nxt    = rem - BYTE_C;
        end else begin
          o_nxt      = o >> 1;
          sticky_nxt = sticky | o[0];
          rem_nxt    = rem - ONE_C;
        end
        if (rem_nxt == '0) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        // ld here is deliberately dropped; a new request needs IDLE.
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // busy/done are flopped from the next state so every output comes
  // straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      o      <= '0;
      sticky <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (ce) begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      o      <= o_nxt;
      sticky <= sticky_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_lz_insert.sv
// Purpose : self-checking bench for lz_insert (WID=64): vector table plus protocol, stall and reset sequences.
// Latency : results are checked against a scoreboard queue filled when ld is driven and drained on each done rising edge.
// Backpress: ce is toggled in the stall sequence to check that done stretches and the result holds.
module tb_lz_insert;

  localparam int WID = 64;
  localparam int CW  = 7;

  logic           clk;
  logic           rst;
  logic           ce;
  logic           ld;
  logic [WID-1:0] i;
  logic [CW-1:0]  cnt;
  logic [WID-1:0] o;
  logic           sticky;
  logic           busy;
  logic           done;

  lz_insert #(.WID(WID), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .ld     (ld),
    .i      (i),
    .cnt    (cnt),
    .o      (o),
    .sticky (sticky),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WID-1:0] vi;
    logic [CW-1:0]  vcnt;
    logic [WID-1:0] vo;
    logic           vs;
    int             lat;
  } vec_t;

  typedef struct {
    logic [WID-1:0] eo;
    logic           es;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one ld cycle; queues the expected result when a done is expected.
  task automatic start(input logic [WID-1:0] vi, input logic [CW-1:0] vcnt,
                       input logic [WID-1:0] vo, input logic vs, input bit push);
    exp_t e;
    ld  = 1'b1;
    i   = vi;
    cnt = vcnt;
    if (push) begin
      e.eo = vo;
      e.es = vs;
      sb_q.push_back(e);
    end
    tick();
    ld  = 1'b0;
    i   = '0;
    cnt = '0;
  endtask

  // lat0 = cycles already elapsed since the ld edge; bounded wait for done.
  task automatic wait_done(input int lat0, input int exp_lat, input string nm);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
    chk(nm, lat, exp_lat);
  endtask

  // Scoreboard monitor: compare on every rising edge of done.
  logic done_prev = 1'b0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_o", o, e.eo);
        chk("sb_sticky", {63'd0, sticky}, {63'd0, e.es});
      end
    end
    done_prev = done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam int NV = 10;
  vec_t vecs[NV];

  initial begin
    bit seen;

    vecs[0] = '{64'h8000_0000_0000_0000, 7'd0,   64'h8000_0000_0000_0000, 1'b0, 1};
    vecs[1] = '{64'hFFFF_0000_0000_0001, 7'd13,  64'h0007_FFF8_0000_0000, 1'b1, 7};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64,  64'h0,                   1'b1, 9};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd100, 64'h0,                   1'b1, 9};
    vecs[4] = '{64'h0,                   7'd64,  64'h0,                   1'b0, 9};
    vecs[5] = '{64'h3,                   7'd1,   64'h1,                   1'b1, 2};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 7'd8,   64'h0001_2345_6789_ABCD, 1'b1, 2};
    vecs[7] = '{64'hF000_0000_0000_0080, 7'd7,   64'h01E0_0000_0000_0001, 1'b0, 8};
    vecs[8] = '{64'h8000_0000_0000_0000, 7'd63,  64'h1,                   1'b0, 15};
    vecs[9] = '{64'h8000_0000_0000_0000, 7'd127, 64'h0,                   1'b1, 9};

    rst = 1'b1;
    ce  = 1'b1;
    ld  = 1'b0;
    i   = '0;
    cnt = '0;
    tick();
    chk("rst_o", o, 64'd0);
    chk("rst_sticky", {63'd0, sticky}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    tick();

    // Vector table.
    for (int k = 0; k < NV; k++) begin
      start(vecs[k].vi, vecs[k].vcnt, vecs[k].vo, vecs[k].vs, 1'b1);
      wait_done(1, vecs[k].lat, $sformatf("vec%0d_latency", k));
      chk($sformatf("vec%0d_busy_at_done", k), {63'd0, busy}, 64'd1);
      tick();
      chk($sformatf("vec%0d_done_clear", k), {63'd0, done}, 64'd0);
      chk($sformatf("vec%0d_busy_clear", k), {63'd0, busy}, 64'd0);
      chk($sformatf("vec%0d_o_hold", k), o, vecs[k].vo);
    end

    // Protocol: ld mid-operation and in the DONE cycle are ignored.
    start(64'hFFFF_0000_0000_0001, 7'd13, 64'h0007_FFF8_0000_0000, 1'b1, 1'b1);
    tick();
    ld = 1'b1; i = 64'h1234; cnt = 7'd2;
    tick();
    ld = 1'b0; i = '0; cnt = '0;
    wait_done(3, 7, "prot_latency");
    ld = 1'b1; i = 64'hFF; cnt = 7'd4;
    tick();
    chk("prot_done_ld_done", {63'd0, done}, 64'd0);
    chk("prot_done_ld_busy", {63'd0, busy}, 64'd0);
    chk("prot_done_ld_o", o, 64'h0007_FFF8_0000_0000);
    start(64'hF0, 7'd4, 64'hF, 1'b0, 1'b1);
    chk("prot_next_busy", {63'd0, busy}, 64'd1);
    wait_done(1, 5, "prot_next_latency");
    tick();

    // Stall: cnt=9 (S=2), 3 dead cycles in SHIFT, 2 in DONE.
    start(64'h300, 7'd9, 64'h1, 1'b1, 1'b1);
    ce = 1'b0;
    tick(); tick(); tick();
    chk("stall_no_done", {63'd0, done}, 64'd0);
    chk("stall_busy", {63'd0, busy}, 64'd1);
    ce = 1'b1;
    wait_done(4, 6, "stall_latency");
    ce = 1'b0;
    tick();
    chk("stall_done_hold1", {63'd0, done}, 64'd1);
    tick();
    chk("stall_done_hold2", {63'd0, done}, 64'd1);
    chk("stall_o_hold", o, 64'h1);
    ce = 1'b1;
    tick();
    chk("stall_done_clear", {63'd0, done}, 64'd0);

    // Reset mid-SHIFT abandons the operation.
    start(64'hFFFF_FFFF_FFFF_FFFF, 7'd40, 64'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_o", o, 64'd0);
    chk("midrst_sticky", {63'd0, sticky}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", {63'd0, seen}, 64'd0);
    start(64'h3, 7'd1, 64'h1, 1'b1, 1'b1);
    wait_done(1, 2, "postrst_latency");
    tick();

    chk("sb_empty", sb_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lz_insert.md
# lz_insert

Multi-cycle denormalizer, the inverse operation of the leading-zero counters. It takes a value and a requested leading-zero count, and right-shifts the value until it carries that many inserted leading zeros. It also produces a sticky bit that ORs together every bit shifted out. It sits on the write-back side of the float/normalize datapath, where exponent underflow requires re-inserting zeros the leading-zero counter removed.

## Interface
- WID, 64: data width; must be a multiple of 8, ≥ 8.
- CW, $clog2(WID)+1: width of the count input; holds 0..WID.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state, including done, holds.
- ld  in  1  start request; sampled only in IDLE with ce=1.
- i  in  WID  value to denormalize; sampled with ld.
- cnt  in  CW  leading zeros to insert; sampled with ld.
- o  out  WID  shifted result; valid while done=1, holds until next accepted ld.
- sticky  out  1  OR of all bits shifted out of o[0] side.
- busy  out  1  high from the cycle after an accepted ld through the DONE cycle.
- done  out  1  one-cycle completion pulse (stretched while ce=0).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, ld=1, ce=1:
  - o←i, sticky←0, rem←c, where c = min(cnt, WID).
  - Next state is SHIFT if c>0, else DONE.
- SHIFT, per ce=1 cycle:
  - If rem≥8: o←o>>8, sticky←sticky | (|o[7:0]), rem←rem−8.
  - Else: o←o>>1, sticky←sticky | o[0], rem←rem−1.
  - If the updated rem is 0, go to DONE.
- DONE: done=1, busy=1; next ce cycle goes to IDLE.
- Step count S = floor(c/8) + (c mod 8).
- Shifts are logical: zeros fill from the MSB.
- Result equals the single-shot expression o = i >> c, with sticky = |(i & ((1<<c)−1)).
- cnt>WID is clamped to WID: o=0, sticky=|i.
- ld outside IDLE is ignored; the in-flight operation is unaffected, and no queueing occurs.
- ld in the DONE cycle is ignored. A new ld is accepted no earlier than the cycle after done.
- rem width is CW; it never underflows.

## Timing
- Reset (rst=1 at an edge, regardless of ce):
  - state=IDLE; o=0, sticky=0, busy=0, done=0, rem=0.
  - A reset mid-operation abandons the operation; no done is produced.
- Latency: with ld accepted at edge N, done is high in the cycle following edge N+S, i.e. S+1 enabled cycles after the ld cycle.
  - c=0: done in the very next cycle.
- Throughput: one operation per S+2 enabled cycles, which includes the DONE→IDLE cycle.
- ce=0 in any state: no transition and no register update.
  - done/busy/o/sticky hold their values.
  - A done pulse therefore stretches for as long as ce stays low.
- o and sticky hold after DONE until the next accepted ld, or until rst.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Zero shift: WID=64, i=64'h8000_0000_0000_0000, cnt=0 → done one cycle after ld; o=64'h8000_0000_0000_0000, sticky=0, busy high one cycle.
- Mixed steps: i=64'hFFFF_0000_0000_0001, cnt=13 → S=6, done 7 cycles after ld; o=64'h0007_FFF8_0000_0000, sticky=1.
- Full and clamped shift:
  - i=all ones, cnt=64 → S=8, done at +9; o=0, sticky=1.
  - Repeat with cnt=100 → identical result and timing.
  - i=0, cnt=64 → o=0, sticky=0.
- Protocol: pulse ld again two cycles into an operation with different i/cnt → ignored; the first result is unchanged. ld during the DONE cycle → ignored. ld on the following cycle → accepted.
- Stall: cnt=9, deassert ce for 3 cycles mid-SHIFT and for 2 cycles during DONE → result correct, done delayed 3 cycles and held high 3 cycles total.
- Reset: assert rst during SHIFT (cnt=40) → next cycle o=0, sticky=0, busy=0, no done. A fresh ld with cnt=1, i=3 → o=1, sticky=1, done at +2.
